// File: rtl/matmul_sched.sv
// Sequencing controller for the matmul accelerator: clears the PE array, feeds K operand
// slices, drains the systolic wavefront and writes N result rows (optionally with bias).
module matmul_sched #(
    parameter int DIM    = 4,
    parameter int IDX_W  = $clog2(DIM),
    parameter int SLOT_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [IDX_W-1:0]  n_dim_i,
    input  logic [IDX_W-1:0]  k_dim_i,
    input  logic [IDX_W-1:0]  m_dim_i,
    input  logic              bias_en_i,
    input  logic [SLOT_W-1:0] wr_slot_i,
    input  logic [SLOT_W-1:0] bias_slot_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              start_err_o,
    output logic              pe_clr_o,
    output logic              pe_en_o,
    output logic              op_rd_en_o,
    output logic [IDX_W-1:0]  op_idx_o,
    output logic              sp_rd_en_o,
    output logic              sp_wr_en_o,
    output logic [SLOT_W-1:0] sp_slot_o,
    output logic [IDX_W-1:0]  sp_row_o,
    output logic              wb_bias_sel_o
);

    localparam int CW = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        WB_RD,
        WB_WR,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic [IDX_W-1:0]  n_q, k_q, m_q;
    logic              bias_q;
    logic [SLOT_W-1:0] wr_slot_q, bias_slot_q;
    logic              start_err_q;
    logic [CW-1:0]     drain_last;
    logic              accept;

    // Drain length spans the full wavefront diagonal; the extra counter bit keeps it from wrapping.
    assign drain_last = {1'b0, n_q} + {1'b0, m_q};
    assign accept     = (state_q == IDLE) && start_i && !abort_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            n_q         <= '0;
            k_q         <= '0;
            m_q         <= '0;
            bias_q      <= 1'b0;
            wr_slot_q   <= '0;
            bias_slot_q <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            start_err_q <= start_i && (state_q != IDLE);
            if (accept) begin
                n_q         <= n_dim_i;
                k_q         <= k_dim_i;
                m_q         <= m_dim_i;
                bias_q      <= bias_en_i;
                wr_slot_q   <= wr_slot_i;
                bias_slot_q <= bias_slot_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == {1'b0, k_q}) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == drain_last) begin
                    state_d = bias_q ? WB_RD : WB_WR;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WB_RD: begin
                state_d = WB_WR;
            end
            WB_WR: begin
                if (row_q == n_q) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + IDX_W'(1);
                    state_d = bias_q ? WB_RD : WB_WR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides whatever transition the current state wanted.
        if (abort_i && (state_q != IDLE)) state_d = IDLE;
    end

    always_comb begin
        busy_o        = (state_q != IDLE);
        done_o        = 1'b0;
        start_err_o   = start_err_q;
        pe_clr_o      = 1'b0;
        pe_en_o       = 1'b0;
        op_rd_en_o    = 1'b0;
        op_idx_o      = '0;
        sp_rd_en_o    = 1'b0;
        sp_wr_en_o    = 1'b0;
        sp_slot_o     = '0;
        sp_row_o      = '0;
        wb_bias_sel_o = 1'b0;
        case (state_q)
            CLEAR: pe_clr_o = 1'b1;
            FEED: begin
                pe_en_o    = 1'b1;
                op_rd_en_o = 1'b1;
                op_idx_o   = cnt_q[IDX_W-1:0];
            end
            DRAIN: pe_en_o = 1'b1;
            WB_RD: begin
                sp_rd_en_o = 1'b1;
                sp_slot_o  = bias_slot_q;
                sp_row_o   = row_q;
            end
            WB_WR: begin
                // Bias read issued in WB_RD arrives now, so the result mux adds it this cycle.
                sp_wr_en_o    = 1'b1;
                wb_bias_sel_o = bias_q;
                sp_slot_o     = wr_slot_q;
                sp_row_o      = row_q;
            end
            DONE: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_sched.sv
// Directed testbench for matmul_sched: checks every output cycle by cycle against a
// schedule derived from the operation's dimensions.
module tb_matmul_sched;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic [1:0] n_dim_i, k_dim_i, m_dim_i;
    logic       bias_en_i;
    logic [1:0] wr_slot_i, bias_slot_i;
    logic       busy_o, done_o, start_err_o, pe_clr_o, pe_en_o, op_rd_en_o;
    logic [1:0] op_idx_o;
    logic       sp_rd_en_o, sp_wr_en_o;
    logic [1:0] sp_slot_o, sp_row_o;
    logic       wb_bias_sel_o;

    int errors = 0;
    int checks = 0;

    matmul_sched #(.DIM(4), .IDX_W(2), .SLOT_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
        .bias_en_i(bias_en_i), .wr_slot_i(wr_slot_i), .bias_slot_i(bias_slot_i),
        .busy_o(busy_o), .done_o(done_o), .start_err_o(start_err_o),
        .pe_clr_o(pe_clr_o), .pe_en_o(pe_en_o), .op_rd_en_o(op_rd_en_o),
        .op_idx_o(op_idx_o), .sp_rd_en_o(sp_rd_en_o), .sp_wr_en_o(sp_wr_en_o),
        .sp_slot_o(sp_slot_o), .sp_row_o(sp_row_o), .wb_bias_sel_o(wb_bias_sel_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] observed();
        return {17'b0, busy_o, done_o, start_err_o, pe_clr_o, pe_en_o, op_rd_en_o,
                op_idx_o, sp_rd_en_o, sp_wr_en_o, sp_slot_o, sp_row_o, wb_bias_sel_o};
    endfunction

    // Expected output vector for cycle i after the start edge (cycle 1 = CLEAR).
    function automatic logic [31:0] expected(int n, int k, int m, bit bias, int ws, int bs,
                                             int i, int ea, int eb, int ab);
        int fe, ds, de, wbs, we, dn, j;
        bit busy, done, serr, clr, en, rd, sprd, spwr, bsel;
        int idx, slot, row;
        fe  = 2 + k;
        ds  = fe + 1;
        de  = ds + n + m;
        wbs = de + 1;
        we  = wbs + (n + 1) * (bias ? 2 : 1) - 1;
        dn  = we + 1;
        {busy, done, clr, en, rd, sprd, spwr, bsel} = '0;
        idx = 0; slot = 0; row = 0;
        serr = (ea != 0 && i == ea + 1) || (eb != 0 && i == eb + 1);
        if (!(ab != 0 && i > ab)) begin
            busy = (i >= 1 && i <= dn);
            clr  = (i == 1);
            done = (i == dn);
            if (i >= 2 && i <= fe) begin
                en = 1'b1; rd = 1'b1; idx = i - 2;
            end
            if (i >= ds && i <= de) en = 1'b1;
            if (i >= wbs && i <= we) begin
                j = i - wbs;
                if (bias) begin
                    row = j / 2;
                    if (j % 2 == 0) begin
                        sprd = 1'b1; slot = bs;
                    end else begin
                        spwr = 1'b1; slot = ws; bsel = 1'b1;
                    end
                end else begin
                    row = j; spwr = 1'b1; slot = ws;
                end
            end
        end
        return {17'b0, busy, done, serr, clr, en, rd, 2'(idx), sprd, spwr,
                2'(slot), 2'(row), bsel};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input int n, input int k, input int m, input bit bias,
                                 input int ws, input int bs);
        n_dim_i = 2'(n); k_dim_i = 2'(k); m_dim_i = 2'(m);
        bias_en_i = bias; wr_slot_i = 2'(ws); bias_slot_i = 2'(bs);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        // Scramble configuration so only the latched copy can produce the right schedule.
        n_dim_i = 2'(3 - n); k_dim_i = 2'(3 - k); m_dim_i = 2'(3 - m);
        bias_en_i = ~bias; wr_slot_i = 2'(bs); bias_slot_i = 2'(ws);
    endtask

    task automatic runOp(input string name, input int n, input int k, input int m,
                         input bit bias, input int ws, input int bs,
                         input int ea, input int eb, input int ab);
        int last;
        last = 1 + (k + 1) + (n + m + 1) + (n + 1) * (bias ? 2 : 1) + 1 + 2;
        applyStimulus(n, k, m, bias, ws, bs);
        for (int i = 1; i <= last; i++) begin
            start_i = (i == ea) || (i == eb);
            abort_i = (i == ab);
            checkOutput($sformatf("%s c%0d", name, i), observed(),
                        expected(n, k, m, bias, ws, bs, i, ea, eb, ab));
            tick();
        end
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
        bias_en_i = 1'b0; wr_slot_i = '0; bias_slot_i = '0;
        repeat (3) tick();
        checkOutput("reset", observed(), 32'h0);
        rst_i = 1'b0;
        repeat (2) tick();

        // 4x4x4 without bias: done 17 cycles after start.
        runOp("op444", 3, 3, 3, 1'b0, 1, 0, 0, 0, 0);
        // n=1,k=2,m=0 with bias alternating reads of slot 1 and writes to slot 2.
        runOp("op231b", 1, 2, 0, 1'b1, 2, 1, 0, 0, 0);
        // Start pulses during FEED (cycle 3) and DONE (cycle 17).
        runOp("starterr", 3, 3, 3, 1'b0, 3, 0, 3, 17, 0);
        // Abort while row 1 is written (cycle 14).
        runOp("abortwb", 3, 3, 3, 1'b0, 1, 2, 0, 0, 14);

        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        checkOutput("abort_start_idle", observed(), 32'h0);
        tick();
        checkOutput("abort_start_idle2", observed(), 32'h0);

        // Reset in the middle of DRAIN (cycle 8).
        applyStimulus(3, 3, 3, 1'b0, 2, 0);
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("prerst c%0d", i), observed(),
                        expected(3, 3, 3, 1'b0, 2, 0, i, 0, 0, 0));
            if (i == 8) rst_i = 1'b1;
            tick();
        end
        checkOutput("rst_mid", observed(), 32'h0);
        rst_i = 1'b0;
        tick();
        checkOutput("rst_after", observed(), 32'h0);
        runOp("postrst", 3, 3, 3, 1'b0, 2, 1, 0, 0, 0);

        runOp("op111", 0, 0, 0, 1'b0, 3, 0, 0, 0, 0);
        runOp("op444b", 3, 3, 3, 1'b1, 0, 3, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
